lcd_timing_gen: RTL and testbench

Parametrised RGB-565 LCD timing and test-pattern generator, driven by `PixelClk`. It produces HSYNC, VSYNC and DE from fully parametrised horizontal and vertical timing, with selectable sync polarity. It drives the LCD colour pins from one of four sources, selected by a frame-synchronous mode register: solid colour, 8 colour bars, a scrolling gradient, or an external pixel stream fed through a request/return path. It sits between the board pixel-clock PLL and the LCD connector and replaces fixed-timing gradient generators.

---
 rtl/lcd_timing_gen.sv | 182 ++++++++++++++++++
 tb/tb_lcd_timing_gen.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/lcd_timing_gen.sv
// RGB-565 LCD timing generator with solid, colour-bar, scrolling-gradient and
// external-stream pixel sources; all LCD pins are registered one cycle after the counters.
module lcd_timing_gen #(
    parameter int H_SYNC      = 1,
    parameter int H_BP        = 42,
    parameter int H_ACTIVE    = 480,
    parameter int H_FP        = 8,
    parameter int V_SYNC      = 10,
    parameter int V_BP        = 2,
    parameter int V_ACTIVE    = 272,
    parameter int V_FP        = 4,
    parameter int HS_POL      = 0,
    parameter int VS_POL      = 0,
    parameter int SCROLL_STEP = 1
) (
    input  logic        PixelClk,
    input  logic        nRST,
    input  logic [1:0]  mode,
    input  logic [15:0] solid_rgb,
    input  logic        scroll_en,
    input  logic [15:0] ext_rgb,
    output logic        pix_req,
    output logic [11:0] pix_x,
    output logic [11:0] pix_y,
    output logic        frame_start,
    output logic        LCD_DE,
    output logic        LCD_HSYNC,
    output logic        LCD_VSYNC,
    output logic [4:0]  LCD_R,
    output logic [5:0]  LCD_G,
    output logic [4:0]  LCD_B
);

    // 13-bit bounds so an end-of-region value of 4096 still compares correctly
    localparam logic [12:0] H_LAST      = 13'(H_SYNC + H_BP + H_ACTIVE + H_FP - 1);
    localparam logic [12:0] V_LAST      = 13'(V_SYNC + V_BP + V_ACTIVE + V_FP - 1);
    localparam logic [12:0] H_SYNC_END  = 13'(H_SYNC);
    localparam logic [12:0] V_SYNC_END  = 13'(V_SYNC);
    localparam logic [12:0] H_ACT_START = 13'(H_SYNC + H_BP);
    localparam logic [12:0] V_ACT_START = 13'(V_SYNC + V_BP);
    localparam logic [12:0] H_ACT_END   = 13'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [12:0] V_ACT_END   = 13'(V_SYNC + V_BP + V_ACTIVE);
    localparam int          BAR_W       = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
    localparam logic [11:0] BAR_LAST    = 12'(BAR_W - 1);
    localparam logic [11:0] STEP        = 12'(SCROLL_STEP % 4096);
    localparam logic        HS_ON       = (HS_POL != 0);
    localparam logic        VS_ON       = (VS_POL != 0);

    typedef enum logic [1:0] {
        MODE_SOLID = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_GRAD  = 2'd2,
        MODE_EXT   = 2'd3
    } mode_e;

    function automatic logic [15:0] bar_colour(input logic [2:0] k);
        bar_colour = {(k[1] ? 5'd0 : 5'd31), (k[2] ? 6'd0 : 6'd63), (k[0] ? 5'd0 : 5'd31)};
    endfunction

    logic [11:0] h_r, v_r, offset_r, bar_cnt_r;
    logic [2:0]  bar_k_r;
    mode_e       mode_r;
    logic        de_r, hs_r, vs_r, fs_r;
    logic [15:0] rgb_r;

    logic [12:0] h_ext_s, v_ext_s;
    logic        h_last_s, v_last_s, frame_top_s, active_s, hs_act_s, vs_act_s;
    logic [11:0] x_s, y_s;
    logic [5:0]  gx_s;
    logic [4:0]  gy_s;
    logic [15:0] pattern_s;

    assign h_ext_s = {1'b0, h_r};
    assign v_ext_s = {1'b0, v_r};

    // Region decode and active-area coordinates from the raw counters
    always_comb begin
        h_last_s    = (h_ext_s == H_LAST);
        v_last_s    = (v_ext_s == V_LAST);
        frame_top_s = (h_r == 12'd0) && (v_r == 12'd0);
        hs_act_s    = (h_ext_s < H_SYNC_END);
        vs_act_s    = (v_ext_s < V_SYNC_END);
        active_s    = (h_ext_s >= H_ACT_START) && (h_ext_s < H_ACT_END) &&
                      (v_ext_s >= V_ACT_START) && (v_ext_s < V_ACT_END);
        if (active_s) begin
            x_s = 12'(h_ext_s - H_ACT_START);
            y_s = 12'(v_ext_s - V_ACT_START);
        end else begin
            x_s = 12'd0;
            y_s = 12'd0;
        end
    end

    assign pix_req = active_s;
    assign pix_x   = x_s;
    assign pix_y   = y_s;

    // Horizontal/vertical position counters
    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            h_r <= 12'd0;
            v_r <= 12'd0;
        end else if (h_last_s) begin
            h_r <= 12'd0;
            v_r <= v_last_s ? 12'd0 : v_r + 12'd1;
        end else begin
            h_r <= h_r + 12'd1;
        end
    end

    // Frame-synchronous mode capture and gradient scroll offset
    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            mode_r   <= MODE_SOLID;
            offset_r <= 12'd0;
        end else begin
            if (frame_top_s) begin
                mode_r <= mode_e'(mode);
            end
            if (h_last_s && v_last_s && scroll_en) begin
                offset_r <= offset_r + STEP;
            end
        end
    end

    // Per-line bar index: advances every BAR_W active pixels, holds at 7
    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            bar_cnt_r <= 12'd0;
            bar_k_r   <= 3'd0;
        end else if (!active_s) begin
            bar_cnt_r <= 12'd0;
            bar_k_r   <= 3'd0;
        end else if (bar_cnt_r == BAR_LAST) begin
            bar_cnt_r <= 12'd0;
            if (bar_k_r != 3'd7) begin
                bar_k_r <= bar_k_r + 3'd1;
            end
        end else begin
            bar_cnt_r <= bar_cnt_r + 12'd1;
        end
    end

    // Pixel source mux; gradient keeps only the sum bits that reach the pins
    always_comb begin
        gx_s = 6'((x_s + offset_r) >> 3);
        gy_s = 5'((y_s + offset_r) >> 4);
        case (mode_r)
            MODE_SOLID: pattern_s = solid_rgb;
            MODE_BARS:  pattern_s = bar_colour(bar_k_r);
            MODE_GRAD:  pattern_s = {gx_s[5:1], 6'd63 - gx_s, gy_s};
            MODE_EXT:   pattern_s = ext_rgb;
            default:    pattern_s = 16'd0;
        endcase
    end

    // Registered LCD pins, one cycle behind the counter state
    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            de_r  <= 1'b0;
            hs_r  <= ~HS_ON;
            vs_r  <= ~VS_ON;
            fs_r  <= 1'b0;
            rgb_r <= 16'd0;
        end else begin
            de_r  <= active_s;
            hs_r  <= hs_act_s ? HS_ON : ~HS_ON;
            vs_r  <= vs_act_s ? VS_ON : ~VS_ON;
            fs_r  <= frame_top_s;
            rgb_r <= active_s ? pattern_s : 16'd0;
        end
    end

    assign LCD_DE      = de_r;
    assign LCD_HSYNC   = hs_r;
    assign LCD_VSYNC   = vs_r;
    assign frame_start = fs_r;
    assign LCD_R       = rgb_r[15:11];
    assign LCD_G       = rgb_r[10:5];
    assign LCD_B       = rgb_r[4:0];

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Randomized bench for lcd_timing_gen on a shrunken raster, checked every cycle
// against a position-arithmetic reference model.
module tb_lcd_timing_gen;

    localparam int HS = 2, HB = 3, HA = 16, HF = 2;
    localparam int VS = 2, VB = 2, VA = 6,  VF = 1;
    localparam int HSP = 1, VSP = 0, STEP = 37;
    localparam int HT = HS + HB + HA + HF;
    localparam int VT = VS + VB + VA + VF;
    localparam int BW = HA / 8;

    logic        PixelClk = 1'b0;
    logic        nRST;
    logic [1:0]  mode;
    logic [15:0] solid_rgb, ext_rgb, salt;
    logic        scroll_en;
    logic        pix_req, frame_start, LCD_DE, LCD_HSYNC, LCD_VSYNC;
    logic [11:0] pix_x, pix_y;
    logic [4:0]  LCD_R, LCD_B;
    logic [5:0]  LCD_G;

    lcd_timing_gen #(
        .H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA), .H_FP(HF),
        .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA), .V_FP(VF),
        .HS_POL(HSP), .VS_POL(VSP), .SCROLL_STEP(STEP)
    ) dut (
        .PixelClk(PixelClk), .nRST(nRST), .mode(mode), .solid_rgb(solid_rgb),
        .scroll_en(scroll_en), .ext_rgb(ext_rgb), .pix_req(pix_req),
        .pix_x(pix_x), .pix_y(pix_y), .frame_start(frame_start),
        .LCD_DE(LCD_DE), .LCD_HSYNC(LCD_HSYNC), .LCD_VSYNC(LCD_VSYNC),
        .LCD_R(LCD_R), .LCD_G(LCD_G), .LCD_B(LCD_B)
    );

    always #5 PixelClk = ~PixelClk;

    // External source answers combinationally from the presented coordinates
    assign ext_rgb = {pix_x[4:0], pix_y[5:0], 5'd0} ^ salt;

    int          mh, mv, moff, mmode;
    logic        e_de, e_hs, e_vs, e_fs;
    logic [15:0] e_rgb;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        mh = 0; mv = 0; moff = 0; mmode = 0;
        e_de = 1'b0; e_fs = 1'b0; e_rgb = 16'd0;
        e_hs = (HSP == 0); e_vs = (VSP == 0);
    endtask

    task automatic model_coords(output logic act, output logic [11:0] px, output logic [11:0] py);
        act = (mh >= HS + HB) && (mh < HS + HB + HA) && (mv >= VS + VB) && (mv < VS + VB + VA);
        px  = act ? 12'(mh - (HS + HB)) : 12'd0;
        py  = act ? 12'(mv - (VS + VB)) : 12'd0;
    endtask

    task automatic model_step();
        logic act;
        logic [11:0] px, py;
        int k, gx, gy, r, g, b;
        if (!nRST) begin
            model_reset();
            return;
        end
        model_coords(act, px, py);
        e_de = act;
        e_hs = ((mh < HS) == (HSP != 0));
        e_vs = ((mv < VS) == (VSP != 0));
        e_fs = (mh == 0) && (mv == 0);
        if (!act) e_rgb = 16'd0;
        else if (mmode == 0) e_rgb = solid_rgb;
        else if (mmode == 1) begin
            k = int'(px) / BW;
            if (k > 7) k = 7;
            r = (k & 2) ? 0 : 31; g = (k & 4) ? 0 : 63; b = (k & 1) ? 0 : 31;
            e_rgb = 16'((r << 11) | (g << 5) | b);
        end else if (mmode == 2) begin
            gx = (int'(px) + moff) % 4096;
            gy = (int'(py) + moff) % 4096;
            r = (gx / 16) % 32; g = 63 - ((gx / 8) % 64); b = (gy / 16) % 32;
            e_rgb = 16'((r << 11) | (g << 5) | b);
        end else e_rgb = {px[4:0], py[5:0], 5'd0} ^ salt;
        if (mh == 0 && mv == 0) mmode = int'(mode);
        if (mh == HT - 1 && mv == VT - 1 && scroll_en) moff = (moff + STEP) % 4096;
        mh = mh + 1;
        if (mh == HT) begin
            mh = 0;
            mv = (mv + 1) % VT;
        end
    endtask

    task automatic cycle();
        logic act;
        logic [11:0] px, py;
        @(negedge PixelClk);
        check("sync", {28'd0, LCD_DE, LCD_HSYNC, LCD_VSYNC, frame_start}, {28'd0, e_de, e_hs, e_vs, e_fs});
        check("rgb", {16'd0, LCD_R, LCD_G, LCD_B}, {16'd0, e_rgb});
        model_coords(act, px, py);
        check("req", {7'd0, pix_req, pix_x, pix_y}, {7'd0, act, px, py});
        model_step();
        @(posedge PixelClk);
        #1;
    endtask

    task automatic run(input int n, input int mode_chg_pct);
        for (int i = 0; i < n; i++) begin
            solid_rgb = 16'($urandom);
            salt      = 16'($urandom);
            if (mode_chg_pct > 0 && $urandom_range(99) < mode_chg_pct) mode = 2'($urandom);
            if (mode_chg_pct > 0 && $urandom_range(99) < 2) scroll_en = 1'($urandom);
            cycle();
        end
    endtask

    task automatic wait_pos(input int h, input int v);
        bit found = 1'b0;
        for (int i = 0; i < 2 * HT * VT && !found; i++) begin
            if (mh == h && mv == v) found = 1'b1;
            else run(1, 0);
        end
        check("wait_pos", {31'd0, found}, 32'd1);
    endtask

    initial begin
        nRST = 1'b1; mode = 2'd0; solid_rgb = 16'hF800; salt = 16'd0; scroll_en = 1'b0;
        model_reset();
        #2 nRST = 1'b0;
        repeat (3) cycle();
        nRST = 1'b1;
        run(HT * VT + 100, 0);             // solid colour
        mode = 2'd1;
        run(2 * HT * VT, 0);               // colour bars
        mode = 2'd2; scroll_en = 1'b1;
        run(4 * HT * VT, 0);               // scrolling gradient
        mode = 2'd3; scroll_en = 1'b0;
        run(2 * HT * VT, 0);               // external stream
        run(8 * HT * VT, 2);               // random mode/scroll changes mid-frame
        wait_pos(HT - 1, VT - 1);          // mode change on the frame-wrap cycle
        mode = mode + 2'd1;
        run(2 * HT * VT, 0);
        mode = 2'd1;
        wait_pos(7, 5);                    // reset in the middle of a frame
        nRST = 1'b0;
        model_reset();
        repeat (3) cycle();
        nRST = 1'b1;
        run(2 * HT * VT, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
